prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter PROG_PAYLD_PKT_BITS, default 48, meaning symbol payload width in bits, a multiple of 8.
REQ-002 SHALL have parameter NUM_SYM_SUPPTD_BITS, default 4, meaning symbol slot count (prog_buffer depth).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1_000_000, meaning max clk_pix cycles between bytes inside one packet.
REQ-004 SHALL have port clk_pix  input  1  pixel clock; the single clock for all logic.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous to clk_pix, active-low.
REQ-006 SHALL have port rx_data  input  8  received byte.
REQ-007 SHALL have port rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-008 SHALL have port frame_start  input  1  one-cycle pulse at start of vertical blanking.
REQ-009 SHALL have port prog_buffer  output  [PROG_PAYLD_PKT_BITS-1:0] x [0:NUM_SYM_SUPPTD_BITS-1]  display copy of symbol slots.
REQ-010 SHALL have port is_prog_mode  output  1  display copy of program-mode flag.
REQ-011 SHALL have port pkt_ok  output  1  one-cycle pulse on each accepted packet.
REQ-012 SHALL have port err_count  output  8  saturating count of rejected packets.
REQ-013 SHALL have port busy  output  1  high while in any state other than IDLE.

Function
REQ-014 SHALL frame packets as header, body, then (if enabled) checksum byte; payload bytes are LSB first.
REQ-015 SHALL use header 0xA5 for WRITE: body = slot index byte, then PROG_PAYLD_PKT_BITS/8 payload bytes.
REQ-016 SHALL use header 0x5A for MODE: body = one byte, bit0 = new mode, bits 7:1 ignored.
REQ-017 SHALL discard any other byte received in IDLE without counting an error.
REQ-018 SHALL implement FSM states IDLE -> INDEX -> PAYLOAD -> CHECK -> IDLE for WRITE, and IDLE -> MODEARG -> CHECK -> IDLE for MODE; a byte counter tracks payload bytes.
REQ-019 SHALL define checksum as the XOR of all body bytes; header excluded.
REQ-020 SHALL, on an accepted packet, write staging slot or staging mode and assert pkt_ok on the cycle after the final byte.
REQ-021 SHALL reject the packet (err_count+1, saturating at 255, no staging write, return to IDLE) on checksum mismatch or slot index >= NUM_SYM_SUPPTD_BITS.
REQ-022 SHALL treat an index error as a rejection only at packet end; it is not an early abort.
REQ-023 SHALL abort to IDLE with err_count+1 when TIMEOUT_CYC cycles pass without rx_valid in any non-IDLE state.
REQ-024 SHALL not resync on 0xA5/0x5A bytes inside a packet; framing is length-based only.
REQ-025 SHALL copy all staging slots and staging mode to prog_buffer/is_prog_mode on frame_start, visible the next cycle; outputs never change at any other time.
REQ-026 SHALL, when a staging write and frame_start coincide, copy the pre-write staging value; the new value appears at the next frame_start.
REQ-027 SHALL ignore rx_valid while rst_n is low.

Reset
REQ-028 SHALL, with rst_n low at a clk_pix edge, set the FSM to IDLE, clear the byte and timeout counters, and zero all staging and display slots.
REQ-029 SHALL, under the same reset, drive is_prog_mode=0, pkt_ok=0, err_count=0, busy=0.
REQ-030 SHALL discard a packet that is in progress when reset asserts, with no error counted.

Configuration
REQ-031 SHALL, with PROG_CHKSUM_EN defined, expect and check the trailing checksum byte.
REQ-032 SHALL, without PROG_CHKSUM_EN, expect no checksum byte, omit the CHECK state, and accept every packet after its last body byte, subject to the index check.

Structure
REQ-033 SHALL place header codes (0xA5, 0x5A), the FSM state enum and the payload field offsets in shared package prog_pkg: height[15:0], width[31:16], r[35:32], g[39:36], b[43:40].
REQ-034 SHALL implement as one module with no sub-modules; the staging and display register arrays stay inline.

Verification (PROG_CHKSUM_EN defined unless noted)
REQ-035 SHALL cover: A5 00 C8 00 96 00 13 02 4F, then frame_start -> pkt_ok pulse; prog_buffer[0]=48'h0213_0096_00C8 one cycle after frame_start, unchanged before it.
REQ-036 SHALL cover: same packet with checksum 4E -> no pkt_ok; err_count=1; prog_buffer[0] stays 0 after frame_start.
REQ-037 SHALL cover: 5A 01 01, then frame_start -> is_prog_mode 0->1 one cycle after frame_start; 5A 00 00 clears it at the next frame_start.
REQ-038 SHALL cover: A5 07 plus 6 bytes plus valid checksum -> rejected; err_count=1; busy low afterwards.
REQ-039 SHALL cover: A5 00 C8 then TIMEOUT_CYC idle cycles -> err_count=1, busy=0; a following valid packet is accepted.
REQ-040 SHALL cover: rst_n low mid-payload -> all outputs at reset values; with PROG_CHKSUM_EN undefined, A5 01 plus 6 bytes is accepted without a checksum byte.

Source files
------------

// File: rtl/prog_pkg.sv
// Shared definitions for the symbol-program loader.
//   - Packet header codes for WRITE and MODE packets.
//   - FSM state encoding. The codes are plain localparams so older tools can
//     use them too.
//   - Bit offsets of the fields packed into a symbol payload word.
// Contains no ports and no logic.
package prog_pkg;

    localparam logic [7:0] HDR_WRITE = 8'hA5;
    localparam logic [7:0] HDR_MODE  = 8'h5A;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_INDEX   = 3'd1;
    localparam state_t ST_PAYLOAD = 3'd2;
    localparam state_t ST_MODEARG = 3'd3;
    localparam state_t ST_CHECK   = 3'd4;

    // Field layout inside one payload word: [msb:lsb].
    localparam int FLD_HEIGHT_LSB = 0;
    localparam int FLD_HEIGHT_MSB = 15;
    localparam int FLD_WIDTH_LSB  = 16;
    localparam int FLD_WIDTH_MSB  = 31;
    localparam int FLD_R_LSB      = 32;
    localparam int FLD_R_MSB      = 35;
    localparam int FLD_G_LSB      = 36;
    localparam int FLD_G_MSB      = 39;
    localparam int FLD_B_LSB      = 40;
    localparam int FLD_B_MSB      = 43;

endpackage

// File: rtl/prog_loader.sv
// prog_loader: receives symbol-program packets over a byte stream and writes
// them into staging registers. The staging registers are copied to the
// display registers on each frame_start.
//
// Packets:
//   WRITE: A5, slot index, payload bytes (LSB first) [, checksum]
//   MODE : 5A, mode byte (bit0 = program mode)        [, checksum]
//   The checksum is the XOR of all body bytes. The header is not included.
//
// Build option: define PROG_CHKSUM_EN to expect and check a trailing
// checksum byte. Without it, a packet ends after its last body byte.
//
// Ports:
//   clk_pix      in   pixel clock, the only clock
//   rst_n        in   synchronous active-low reset
//   rx_data      in   received byte
//   rx_valid     in   one-cycle strobe that qualifies rx_data
//   frame_start  in   copies staging to display; the copy is visible next cycle
//   prog_buffer  out  display copy of the symbol slots
//   is_prog_mode out  display copy of the program-mode flag
//   pkt_ok       out  one-cycle pulse for each accepted packet
//   err_count    out  count of rejected or timed-out packets; saturates at 255
//   busy         out  high whenever the FSM is not in IDLE
//   dbg_state    out  raw FSM state, for observation only
module prog_loader
    import prog_pkg::*;
#(
    parameter int PROG_PAYLD_PKT_BITS = 48,
    parameter int NUM_SYM_SUPPTD_BITS = 4,
    parameter int TIMEOUT_CYC         = 1_000_000
) (
    input  logic                           clk_pix,
    input  logic                           rst_n,
    input  logic [7:0]                     rx_data,
    input  logic                           rx_valid,
    input  logic                           frame_start,
    output logic [PROG_PAYLD_PKT_BITS-1:0] prog_buffer [0:NUM_SYM_SUPPTD_BITS-1],
    output logic                           is_prog_mode,
    output logic                           pkt_ok,
    output logic [7:0]                     err_count,
    output logic                           busy,
    output logic [2:0]                     dbg_state
);

    localparam int NB = PROG_PAYLD_PKT_BITS / 8;
    localparam int CW = $clog2(NB + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    state_t                         state_q, state_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [TW-1:0]                  tmo_q, tmo_d;
    logic [7:0]                     idx_q, idx_d;
    logic [PROG_PAYLD_PKT_BITS-1:0] pay_q, pay_d;
    logic [7:0]                     csum_q, csum_d;
    logic                           marg_q, marg_d;
    logic                           is_wr_q, is_wr_d;
    logic                           pkt_ok_q;
    logic [7:0]                     err_q;

    logic [PROG_PAYLD_PKT_BITS-1:0] stage_q [NUM_SYM_SUPPTD_BITS];
    logic [PROG_PAYLD_PKT_BITS-1:0] disp_q  [NUM_SYM_SUPPTD_BITS];
    logic                           stage_mode_q, disp_mode_q;

    logic fin;        // the final byte of a packet is sampled this cycle
    logic chk_ok;     // the checksum matches, or the checksum is not in use
    logic idx_ok;
    logic tmo_abort;
    logic accept;
    logic reject;

    assign idx_ok = int'(idx_q) < NUM_SYM_SUPPTD_BITS;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        idx_d     = idx_q;
        pay_d     = pay_q;
        csum_d    = csum_q;
        marg_d    = marg_q;
        is_wr_d   = is_wr_q;
        fin       = 1'b0;
        chk_ok    = 1'b0;
        tmo_abort = 1'b0;

        // The inter-byte timeout runs only while a packet is open.
        if (state_q != ST_IDLE) begin
            if (rx_valid) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_LAST) begin
                tmo_abort = 1'b1;
                tmo_d     = '0;
                state_d   = ST_IDLE;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        // Framing depends only on length. Header codes seen inside a packet
        // are treated as ordinary data.
        if (rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    csum_d = '0;
                    cnt_d  = '0;
                    if (rx_data == HDR_WRITE) begin
                        is_wr_d = 1'b1;
                        state_d = ST_INDEX;
                    end else if (rx_data == HDR_MODE) begin
                        is_wr_d = 1'b0;
                        state_d = ST_MODEARG;
                    end
                end
                ST_INDEX: begin
                    idx_d   = rx_data;
                    csum_d  = csum_q ^ rx_data;
                    state_d = ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    for (int k = 0; k < NB; k++) begin
                        if (cnt_q == CW'(k)) pay_d[k*8 +: 8] = rx_data;
                    end
                    csum_d = csum_q ^ rx_data;
                    if (cnt_q == CW'(NB - 1)) begin
`ifdef PROG_CHKSUM_EN
                        state_d = ST_CHECK;
`else
                        fin     = 1'b1;
                        chk_ok  = 1'b1;
                        state_d = ST_IDLE;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_MODEARG: begin
                    marg_d = rx_data[0];
                    csum_d = csum_q ^ rx_data;
`ifdef PROG_CHKSUM_EN
                    state_d = ST_CHECK;
`else
                    fin     = 1'b1;
                    chk_ok  = 1'b1;
                    state_d = ST_IDLE;
`endif
                end
`ifdef PROG_CHKSUM_EN
                ST_CHECK: begin
                    fin     = 1'b1;
                    chk_ok  = (rx_data == csum_q);
                    state_d = ST_IDLE;
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end

        // A bad index is detected only when the packet ends, so the bytes
        // that follow it are still consumed as part of the packet.
        accept = fin && chk_ok && (!is_wr_q || idx_ok);
        reject = (fin && !accept) || tmo_abort;
    end

    always_ff @(posedge clk_pix) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            tmo_q        <= '0;
            idx_q        <= '0;
            pay_q        <= '0;
            csum_q       <= '0;
            marg_q       <= 1'b0;
            is_wr_q      <= 1'b0;
            pkt_ok_q     <= 1'b0;
            err_q        <= '0;
            stage_mode_q <= 1'b0;
            disp_mode_q  <= 1'b0;
            for (int s = 0; s < NUM_SYM_SUPPTD_BITS; s++) begin
                stage_q[s] <= '0;
                disp_q[s]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            idx_q    <= idx_d;
            pay_q    <= pay_d;
            csum_q   <= csum_d;
            marg_q   <= marg_d;
            is_wr_q  <= is_wr_d;
            pkt_ok_q <= accept;
            if (reject && err_q != 8'hFF) err_q <= err_q + 8'd1;
            if (accept && !is_wr_q) stage_mode_q <= marg_d;
            // The display copy reads the staging values from before this
            // cycle's write, so a write that lands with frame_start shows up
            // at the next frame.
            for (int s = 0; s < NUM_SYM_SUPPTD_BITS; s++) begin
                if (accept && is_wr_q && idx_q == 8'(s)) stage_q[s] <= pay_d;
                if (frame_start) disp_q[s] <= stage_q[s];
            end
            if (frame_start) disp_mode_q <= stage_mode_q;
        end
    end

    assign prog_buffer  = disp_q;
    assign is_prog_mode = disp_mode_q;
    assign pkt_ok       = pkt_ok_q;
    assign err_count    = err_q;
    assign busy         = (state_q != ST_IDLE);
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader. It works with or without PROG_CHKSUM_EN.
// Packet outcomes (accepted or rejected) go into a queue when a packet is sent.
// A negedge monitor pops one entry for each pkt_ok pulse or err_count step.
// A reference model of the staging and display registers predicts prog_buffer.
module tb_prog_loader;
    localparam int PW  = 48;
    localparam int NS  = 4;
    localparam int TMO = 40;
    localparam int NB  = PW / 8;

    logic          clk_pix     = 1'b0;
    logic          rst_n       = 1'b0;
    logic [7:0]    rx_data     = 8'h00;
    logic          rx_valid    = 1'b0;
    logic          frame_start = 1'b0;
    logic [PW-1:0] prog_buffer [0:NS-1];
    logic          is_prog_mode;
    logic          pkt_ok;
    logic [7:0]    err_count;
    logic          busy;
    logic [2:0]    dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Outcome codes: 1 = accepted (pkt_ok), 2 = rejected (err_count step).
    logic [1:0]    exp_q[$];
    logic [PW-1:0] m_stage [NS];
    logic [PW-1:0] m_disp  [NS];
    logic          m_mode_stage;
    logic          m_mode_disp;
    int            m_err;
    logic [7:0]    last_err = 8'h00;
    logic [1:0]    mon_got;

    prog_loader #(
        .PROG_PAYLD_PKT_BITS (PW),
        .NUM_SYM_SUPPTD_BITS (NS),
        .TIMEOUT_CYC         (TMO)
    ) dut (
        .clk_pix      (clk_pix),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .frame_start  (frame_start),
        .prog_buffer  (prog_buffer),
        .is_prog_mode (is_prog_mode),
        .pkt_ok       (pkt_ok),
        .err_count    (err_count),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk_pix = ~clk_pix;

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: each completion event pops one expected outcome.
    always @(negedge clk_pix) begin
        if (rst_n && (pkt_ok || err_count != last_err)) begin
            mon_got = pkt_ok ? 2'd1 : 2'd2;
            if (exp_q.size() == 0) check_eq("evt_unexpected", 64'(mon_got), 64'd0);
            else                   check_eq("evt_outcome", 64'(mon_got), 64'(exp_q.pop_front()));
        end
        last_err = err_count;
    end

    // ---------------- model helpers ----------------
    task automatic model_clear();
        for (int s = 0; s < NS; s++) begin
            m_stage[s] = '0;
            m_disp[s]  = '0;
        end
        m_mode_stage = 1'b0;
        m_mode_disp  = 1'b0;
        m_err        = 0;
    endtask

    task automatic model_copy();
        for (int s = 0; s < NS; s++) m_disp[s] = m_stage[s];
        m_mode_disp = m_mode_stage;
    endtask

    task automatic model_reject();
        if (m_err < 255) m_err++;
    endtask

    task automatic check_display(input string tag);
        for (int s = 0; s < NS; s++)
            check_eq($sformatf("%s_slot%0d", tag, s), 64'(prog_buffer[s]), 64'(m_disp[s]));
        check_eq({tag, "_mode"}, 64'(is_prog_mode), 64'(m_mode_disp));
    endtask

    // ---------------- drivers (enter and leave at a negedge) ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk_pix);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic fs);
        rx_data     = b;
        rx_valid    = 1'b1;
        frame_start = fs;
        @(negedge clk_pix);
        rx_valid    = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic send_write(input logic [7:0] idx, input logic [PW-1:0] pay,
                              input logic bad, input logic fs_last);
        logic [7:0] cs;
        logic       ok;
        cs = idx;
        for (int k = 0; k < NB; k++) cs = cs ^ pay[k*8 +: 8];
        ok = (idx < NS);
`ifdef PROG_CHKSUM_EN
        if (bad) ok = 1'b0;
`endif
        exp_q.push_back(ok ? 2'd1 : 2'd2);
        if (!ok) model_reject();
        send_byte(8'hA5, 1'b0);
        send_byte(idx, 1'b0);
`ifdef PROG_CHKSUM_EN
        for (int k = 0; k < NB; k++) send_byte(pay[k*8 +: 8], 1'b0);
        send_byte(bad ? (cs ^ 8'h01) : cs, fs_last);
`else
        for (int k = 0; k < NB - 1; k++) send_byte(pay[k*8 +: 8], 1'b0);
        send_byte(pay[(NB-1)*8 +: 8], fs_last);
`endif
        if (fs_last) model_copy();
        if (ok) m_stage[int'(idx)] = pay;
    endtask

    task automatic send_mode(input logic [7:0] arg, input logic bad);
        logic ok;
        ok = 1'b1;
`ifdef PROG_CHKSUM_EN
        if (bad) ok = 1'b0;
`endif
        exp_q.push_back(ok ? 2'd1 : 2'd2);
        if (!ok) model_reject();
        send_byte(8'h5A, 1'b0);
        send_byte(arg, 1'b0);
`ifdef PROG_CHKSUM_EN
        send_byte(bad ? (arg ^ 8'h01) : arg, 1'b0);
`endif
        if (ok) m_mode_stage = arg[0];
    endtask

    task automatic do_frame();
        frame_start = 1'b1;
        @(negedge clk_pix);
        frame_start = 1'b0;
        model_copy();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_pkt_ok"}, 64'(pkt_ok), 64'd0);
        check_eq({tag, "_err"}, 64'(err_count), 64'd0);
        check_eq({tag, "_mode"}, 64'(is_prog_mode), 64'd0);
        for (int s = 0; s < NS; s++)
            check_eq($sformatf("%s_slot%0d", tag, s), 64'(prog_buffer[s]), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0]   rnd;
        logic [7:0]    ridx;
        logic          rbad;

        model_clear();
        rst_n = 1'b0;
        tick(3);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick(1);

        // Reference packet. The display must not change until frame_start.
        send_write(8'd0, 48'h0213_0096_00C8, 1'b0, 1'b0);
        tick(2);
        check_eq("t1_pre_fs_slot0", 64'(prog_buffer[0]), 64'd0);
        do_frame();
        check_eq("t1_slot0_literal", 64'(prog_buffer[0]), 64'h0213_0096_00C8);
        check_display("t1");

        // Corrupted checksum (accepted when the checksum is not in use).
        send_write(8'd1, 48'h0213_0096_00C8, 1'b1, 1'b0);
        tick(2);
        check_eq("t2_err", 64'(err_count), 64'(m_err));
        do_frame();
        check_display("t2");

        // Mode set, then clear; each change takes effect only at frame_start.
        send_mode(8'h01, 1'b0);
        tick(2);
        check_eq("t3_mode_pre", 64'(is_prog_mode), 64'd0);
        do_frame();
        check_eq("t3_mode_set", 64'(is_prog_mode), 64'd1);
        send_mode(8'h00, 1'b0);
        tick(2);
        check_eq("t3_mode_hold", 64'(is_prog_mode), 64'd1);
        do_frame();
        check_eq("t3_mode_clr", 64'(is_prog_mode), 64'd0);

        // Mode byte with upper bits set: only bit0 matters.
        send_mode(8'hFE, 1'b0);
        tick(1);
        do_frame();
        check_display("t3b");

        // Out-of-range slot index.
        send_write(8'd7, 48'h1122_3344_5566, 1'b0, 1'b0);
        tick(2);
        check_eq("t4_err", 64'(err_count), 64'(m_err));
        check_eq("t4_busy", 64'(busy), 64'd0);

        // Bytes other than a header while IDLE are dropped silently.
        send_byte(8'h33, 1'b0);
        send_byte(8'h00, 1'b0);
        tick(2);
        check_eq("idle_junk_busy", 64'(busy), 64'd0);
        check_eq("idle_junk_err", 64'(err_count), 64'(m_err));

        // Header codes inside the payload are treated as data.
        send_write(8'd2, 48'h5AA5_5AA5_A55A, 1'b0, 1'b0);
        tick(1);
        check_eq("noresync_busy", 64'(busy), 64'd0);
        do_frame();
        check_display("noresync");

        // Timeout in the middle of the payload.
        exp_q.push_back(2'd2);
        model_reject();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hC8, 1'b0);
        tick(TMO - 1);
        check_eq("tmo_busy_before", 64'(busy), 64'd1);
        tick(1);
        check_eq("tmo_busy_after", 64'(busy), 64'd0);
        check_eq("tmo_err", 64'(err_count), 64'(m_err));
        send_write(8'd3, 48'hBEEF_0000_CAFE, 1'b0, 1'b0);
        tick(1);
        do_frame();
        check_display("tmo_next");

        // Staging write in the same cycle as frame_start: the old value is copied.
        send_write(8'd0, 48'h0102_0304_0506, 1'b0, 1'b1);
        tick(1);
        check_display("coinc_old");
        do_frame();
        check_display("coinc_new");

        // Random traffic: some bad indices and some bad checksums.
        for (int n = 0; n < 10; n++) begin
            rnd  = {$urandom, $urandom};
            ridx = 8'($urandom_range(0, 5));
            rbad = ($urandom_range(0, 3) == 0);
            send_write(ridx, rnd[PW-1:0], rbad, 1'b0);
            if ($urandom_range(0, 2) == 0) send_mode(8'($urandom_range(0, 255)), 1'b0);
            tick($urandom_range(0, 3));
        end
        tick(1);
        do_frame();
        check_display("rand");
        check_eq("rand_err", 64'(err_count), 64'(m_err));

        // Reset in the middle of the payload discards the packet without an error.
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hC8, 1'b0);
        send_byte(8'h00, 1'b0);
        rst_n = 1'b0;
        rx_data  = 8'h96;
        rx_valid = 1'b1;
        tick(2);
        rx_valid = 1'b0;
        check_reset_outputs("midrst");
        model_clear();
        rst_n = 1'b1;
        tick(1);
        check_eq("midrst_busy_after", 64'(busy), 64'd0);

        send_write(8'd1, 48'h0000_00FF_EE11, 1'b0, 1'b0);
        tick(1);
        do_frame();
        check_display("postrst");

        tick(4);
        check_eq("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
